// File: rtl/pc_unit.sv
// Program-counter stage: holds the fetch address and picks the next one from
// sequential increment, a live branch/jump, or a redirect parked during stall.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        redirect_pending
);

  localparam logic [1:0] S_RESET = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_HELD  = 2'b10;

  typedef struct packed {
    logic        vld;
    logic [31:0] tgt;
  } redir_t;

  logic [1:0]  state;
  logic [31:0] pend_addr;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  redir_t      redir;

  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], jump_index, 2'b00};

  // Jump outranks a simultaneously taken branch.
  always_comb begin
    redir.vld = jump | branch_taken;
    redir.tgt = jump ? jmp_tgt : br_tgt;
  end

  assign fetch_valid      = (state != S_RESET) & ~stall;
  assign redirect_pending = (state == S_HELD);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc        <= RESET_VECTOR;
      pend_addr <= 32'h0;
      state     <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_RUN;
        default: begin
          if (stall) begin
            // Newest redirect seen during a stall wins.
            if (redir.vld) begin
              pend_addr <= redir.tgt;
              state     <= S_HELD;
            end
          end else if (redir.vld) begin
            pc    <= redir.tgt;
            state <= S_RUN;
          end else if (state == S_HELD) begin
            pc    <= pend_addr;
            state <= S_RUN;
          end else begin
            pc <= pc_plus4;
          end
        end
      endcase
    end
  end

endmodule
